dram_rd_arbiter: RTL and testbench
==================================

# dram_rd_arbiter

Round-robin arbiter that shares the single VCNPU external DRAM read port (dram_req/dram_addr/dram_len/dram_ack/dram_data_valid/dram_data_in) between several on-chip requesters, such as the reference-frame fetcher and the weight/bias fetcher. It accepts one burst request at a time and drives the DRAM handshake. It counts returning beats and steers each beat to the owning requester. It flags stalled transactions with a sticky error. It sits inside vcnpu_top, between the requesters and the top-level DRAM pins.

## Interface
- N_REQ, 3, number of requesters (2..8)
- DATA_W, 16, DRAM data beat width
- ADDR_W, 32, address width
- LEN_W, 16, burst length width (beats)
- TIMEOUT, 1024, max cycles without ack/beat before abort

Ports. Reset is rst_n, asynchronous, active-low; the clock is clk.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  N_REQ  per-requester request; held until grant
- req_addr  in  N_REQ*ADDR_W  packed start addresses (requester i at bits [i*ADDR_W +: ADDR_W])
- req_len  in  N_REQ*LEN_W  packed burst lengths
- req_grant  out  N_REQ  one-hot, one-cycle grant pulse
- rsp_valid  out  N_REQ  one-hot beat strobe to owner
- rsp_data  out  DATA_W  beat data (shared bus)
- rsp_last  out  1  qualifies final beat (with rsp_valid) or zero-length completion
- dram_req  out  1  DRAM read request
- dram_addr  out  ADDR_W  latched burst address
- dram_len  out  LEN_W  latched burst length
- dram_ack  in  1  DRAM accepts request
- dram_data_valid  in  1  DRAM beat valid
- dram_data_in  in  DATA_W  DRAM beat data
- err_clr  in  1  clears sticky error
- busy  out  1  state != IDLE
- error  out  1  sticky timeout flag
- owner  out  $clog2(N_REQ) (min 1)  current/last owner index

## Operation
- States: IDLE, REQ, DATA.
- IDLE: if any req_valid, pick the first set bit scanning upward from rr_ptr (wraps). Latch owner, addr and len. Pulse req_grant[owner]. Set rr_ptr = owner+1 mod N_REQ.
  - len != 0: go to REQ.
  - len == 0: no DRAM request; go to IDLE with rsp_last=1 and rsp_valid[owner]=1 for that cycle (rsp_data=0).
- REQ: dram_req=1. On a dram_ack sampled high, dram_req drops on that edge and the state goes to DATA.
- DATA: each dram_data_valid beat produces rsp_valid[owner]=1 and rsp_data=dram_data_in one cycle later, and increments the beat counter (LEN_W bits). The beat where count == len-1 also sets rsp_last and returns the state to IDLE. Extra beats beyond len are ignored.
- Beats arriving in IDLE/REQ are dropped silently.
- The requester deasserts req_valid in its grant cycle. The arbiter samples req_valid only in IDLE. A request still high after grant is treated as a new request.
- Timeout counter:
  - Clears on entry to REQ and on each accepted beat.
  - Increments in REQ/DATA.
  - At TIMEOUT: error=1, dram_req=0, state to IDLE, no rsp_last, and rr_ptr is kept as already advanced.
- error clears only on err_clr or reset. Arbitration continues while error=1.
- dram_addr/dram_len hold their last latched value outside REQ/DATA.

## Timing
- Reset values: all outputs 0; rr_ptr=0; owner=0; state IDLE.
- Grant latency: req_valid high before edge k gives req_grant and dram_req high in cycle k (registered).
- dram_req is high for ack latency + 1 cycles; with the combinational ack model it is high exactly 1 cycle after ack rises.
- Beat latency: dram_data_valid at edge k gives rsp_valid in cycle k.
- Minimum gap: one IDLE cycle between the last beat of one burst and the next grant.
- Simultaneous req_valid from several requesters: exactly one grant, chosen round-robin. Others wait; there is no starvation within N_REQ bursts.
- Reset mid-burst: immediate return to IDLE, all outputs 0, beat count discarded; the DRAM side must be reset too.
- err_clr in the same cycle a timeout fires: the set wins.

## Test plan
- Single request: req0 addr 0x1000_0000, len 4, ack 1 cycle later, 4 beats 0xA001..0xA004 -> one grant[0] pulse, dram_addr=0x1000_0000, dram_len=4, rsp_valid[0] ×4 with matching data, rsp_last on 0xA004, busy low afterward.
- Contention: req0, req1 and req2 all high continuously, len 2 each -> grant order 0,1,2,0,1,2; each burst delivered only to its owner.
- Round-robin pointer: after a grant to 1, requests 0 and 2 simultaneous -> grant goes to 2 first.
- Zero length: req1 len 0 -> grant[1], dram_req never high, rsp_valid[1]+rsp_last in the same cycle, back to IDLE.
- Timeout: TIMEOUT=16, dram_ack tied 0 -> dram_req drops after 16 cycles, error=1 and sticky. Next request still granted. err_clr -> error=0.
- Reset mid-DATA: assert rst_n low after 2 of 8 beats -> all outputs 0 immediately. After release, a new len 3 burst completes with exactly 3 beats.

Source files
------------

// File: rtl/dram_rd_arbiter.sv
// dram_rd_arbiter: round-robin owner of the shared DRAM read port. Steers returned
// beats to the granted requester and aborts stalled bursts with a sticky error.
//   state | meaning
//   IDLE  | arbitrating; zero-length requests complete here without DRAM traffic
//   REQ   | dram_req high, waiting for dram_ack
//   DATA  | counting returned beats for the current owner
module dram_rd_arbiter #(
  parameter int N_REQ   = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [N_REQ-1:0]                           req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]                    req_addr_i,
  input  logic [N_REQ*LEN_W-1:0]                     req_len_i,
  output logic [N_REQ-1:0]                           req_grant_o,
  output logic [N_REQ-1:0]                           rsp_valid_o,
  output logic [DATA_W-1:0]                          rsp_data_o,
  output logic                                       rsp_last_o,
  output logic                                       dram_req_o,
  output logic [ADDR_W-1:0]                          dram_addr_o,
  output logic [LEN_W-1:0]                           dram_len_o,
  input  logic                                       dram_ack_i,
  input  logic                                       dram_data_valid_i,
  input  logic [DATA_W-1:0]                          dram_data_in_i,
  input  logic                                       err_clr_i,
  output logic                                       busy_o,
  output logic                                       error_o,
  output logic [$clog2((N_REQ > 1) ? N_REQ : 2)-1:0] owner_o
);

  localparam int OWN_W = $clog2((N_REQ > 1) ? N_REQ : 2);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 error_q, error_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_last_q, rsp_last_d;

  logic [2*N_REQ-1:0]   req_dbl;
  logic [N_REQ-1:0]     req_rot;
  logic                 any_req;
  logic [OWN_W-1:0]     pick;
  logic [ADDR_W-1:0]    pick_addr;
  logic [LEN_W-1:0]     pick_len;
  logic                 tmo_hit;
  logic                 last_beat;

  // Rotating the request vector by rr_ptr turns round-robin into a lowest-bit-first search.
  assign req_dbl   = {req_valid_i, req_valid_i};
  assign req_rot   = req_dbl[rr_ptr_q +: N_REQ];
  assign any_req   = |req_valid_i;
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign last_beat = (beat_q == (len_q - LEN_W'(1)));

  always_comb begin : arb_scan
    int slot;
    pick = '0;
    slot = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        slot = int'(rr_ptr_q) + k;
        if (slot >= N_REQ) slot = slot - N_REQ;
        pick = OWN_W'(slot);
      end
    end
  end

  always_comb begin : pick_mux
    pick_addr = '0;
    pick_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == OWN_W'(i)) begin
        pick_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        pick_len  = req_len_i[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_state
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (any_req && (pick_len != '0)) state_d = S_REQ;
      S_REQ: begin
        if (dram_ack_i)   state_d = S_DATA;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_DATA: begin
        if (dram_data_valid_i) begin
          if (last_beat) state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    error_d     = error_q & ~err_clr_i;
    grant_d     = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_last_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d  = pick;
          addr_d   = pick_addr;
          len_d    = pick_len;
          beat_d   = '0;
          tmo_d    = '0;
          grant_d  = N_REQ'(1) << pick;
          rr_ptr_d = (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;
          if (pick_len == '0) begin
            rsp_valid_d = N_REQ'(1) << pick;
            rsp_last_d  = 1'b1;
          end
        end
      end
      S_REQ: begin
        // The stall counter saturates; an ack on the final cycle still wins.
        if (!tmo_hit) tmo_d = tmo_q + 1'b1;
        if (!dram_ack_i && tmo_hit) error_d = 1'b1;
      end
      S_DATA: begin
        if (dram_data_valid_i) begin
          tmo_d       = '0;
          beat_d      = beat_q + 1'b1;
          rsp_valid_d = N_REQ'(1) << owner_q;
          rsp_data_d  = dram_data_in_i;
          rsp_last_d  = last_beat;
        end else begin
          if (!tmo_hit) tmo_d = tmo_q + 1'b1;
          else          error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : dp_regs
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      error_q     <= 1'b0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      error_q     <= error_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign req_grant_o = grant_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;
  assign dram_req_o  = (state_q == S_REQ);
  assign dram_addr_o = addr_q;
  assign dram_len_o  = len_q;
  assign busy_o      = (state_q != S_IDLE);
  assign error_o     = error_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// tb_dram_rd_arbiter: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a transaction-level model of the arbiter.
module tb_dram_rd_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int DW = 16;
  localparam int TO = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_grant_o;
  logic [N-1:0]    rsp_valid_o;
  logic [DW-1:0]   rsp_data_o;
  logic            rsp_last_o;
  logic            dram_req_o;
  logic [AW-1:0]   dram_addr_o;
  logic [LW-1:0]   dram_len_o;
  logic            dram_ack;
  logic            dram_data_valid;
  logic [DW-1:0]   dram_data_in;
  logic            err_clr;
  logic            busy_o;
  logic            error_o;
  logic [1:0]      owner_o;

  int n_pass;
  int n_total;
  bit check_en;

  dram_rd_arbiter #(
    .N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_len_i(req_len),
    .req_grant_o(req_grant_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .rsp_last_o(rsp_last_o), .dram_req_o(dram_req_o), .dram_addr_o(dram_addr_o),
    .dram_len_o(dram_len_o), .dram_ack_i(dram_ack), .dram_data_valid_i(dram_data_valid),
    .dram_data_in_i(dram_data_in), .err_clr_i(err_clr), .busy_o(busy_o),
    .error_o(error_o), .owner_o(owner_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: phase 0 = no burst, 1 = waiting for ack, 2 = receiving beats.
  int          m_phase, m_ptr, m_owner, m_len, m_cnt, m_since;
  logic [31:0] m_addr;
  logic        m_err;
  logic [N-1:0] e_grant, e_rv;
  logic [DW-1:0] e_data;
  logic        e_last;

  initial begin : model
    bit fired, prog;
    int pick, p;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_ptr = 0; m_owner = 0; m_len = 0; m_cnt = 0; m_since = 0;
        m_addr = '0; m_err = 1'b0;
        e_grant = '0; e_rv = '0; e_data = '0; e_last = 1'b0;
      end else begin
        e_grant = '0; e_rv = '0; e_data = '0; e_last = 1'b0; fired = 1'b0;
        if (m_phase == 0) begin
          pick = -1;
          for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (pick < 0 && req_valid[p]) pick = p;
          end
          if (pick >= 0) begin
            m_owner = pick;
            m_addr  = req_addr[pick*AW +: AW];
            m_len   = int'(req_len[pick*LW +: LW]);
            m_cnt   = 0;
            m_since = 0;
            m_ptr   = (pick + 1) % N;
            e_grant = N'(1 << pick);
            if (m_len == 0) begin
              e_rv   = e_grant;
              e_last = 1'b1;
            end else begin
              m_phase = 1;
            end
          end
        end else begin
          prog = (m_phase == 1) ? dram_ack : dram_data_valid;
          if (!prog && m_since >= TO - 1) begin
            fired = 1'b1; m_err = 1'b1; m_phase = 0;
          end else if (m_phase == 1) begin
            m_since++;
            if (prog) m_phase = 2;
          end else if (prog) begin
            m_since = 0;
            e_rv    = N'(1 << m_owner);
            e_data  = dram_data_in;
            m_cnt++;
            if (m_cnt == m_len) begin
              e_last  = 1'b1;
              m_phase = 0;
            end
          end else begin
            m_since++;
          end
        end
        if (err_clr && !fired) m_err = 1'b0;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("req_grant", req_grant_o, e_grant);
        chk("rsp_valid", rsp_valid_o, e_rv);
        chk("rsp_last", rsp_last_o, e_last);
        if (e_rv != '0) chk("rsp_data", rsp_data_o, e_data);
        chk("dram_req", dram_req_o, m_phase == 1);
        chk("busy", busy_o, m_phase != 0);
        chk("error", error_o, m_err);
        chk("owner", owner_o, m_owner);
        chk("dram_addr", dram_addr_o, m_addr);
        chk("dram_len", dram_len_o, m_len);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [31:0] addr, input logic [15:0] len);
    req_addr[idx*AW +: AW] = addr;
    req_len[idx*LW +: LW]  = len;
    req_valid[idx]         = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, req_grant_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_last"}, rsp_last_o, 0);
    chk({tag, "_rsp_data"}, rsp_data_o, 0);
    chk({tag, "_dram_req"}, dram_req_o, 0);
    chk({tag, "_dram_addr"}, dram_addr_o, 0);
    chk({tag, "_dram_len"}, dram_len_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_error"}, error_o, 0);
    chk({tag, "_owner"}, owner_o, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; dram_ack = 1'b0; dram_data_valid = 1'b0; err_clr = 1'b0;
    #1;
    chk_zero("rst");
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (req_grant_o == '0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_grant_seen"}, n < 20, 1);
  endtask

  task automatic run_burst(input int idx, input int len, input logic [15:0] base, input bit drop);
    wait_grant("burst");
    chk("burst_grant", req_grant_o, 64'(1) << idx);
    chk("burst_addr", dram_addr_o, req_addr[idx*AW +: AW]);
    chk("burst_len", dram_len_o, 64'(len));
    if (drop) req_valid[idx] = 1'b0;
    if (len == 0) begin
      chk("zl_rsp_valid", rsp_valid_o, 64'(1) << idx);
      chk("zl_rsp_last", rsp_last_o, 1);
      chk("zl_dram_req", dram_req_o, 0);
      chk("zl_busy", busy_o, 0);
      chk("zl_rsp_data", rsp_data_o, 0);
    end else begin
      chk("burst_dram_req", dram_req_o, 1);
      dram_ack = 1'b1;
      tick();
      dram_ack = 1'b0;
      chk("burst_req_drop", dram_req_o, 0);
      for (int j = 0; j < len; j++) begin
        dram_data_valid = 1'b1;
        dram_data_in    = 16'(base + 16'(j));
        tick();
        chk("beat_valid", rsp_valid_o, 64'(1) << idx);
        chk("beat_data", rsp_data_o, 16'(base + 16'(j)));
        chk("beat_last", rsp_last_o, j == len - 1);
      end
      dram_data_valid = 1'b0;
      chk("burst_done_busy", busy_o, 0);
    end
  endtask

  initial begin : stim
    int n;
    int ack_pct;
    n_pass = 0; n_total = 0; check_en = 1'b0;
    rst_n = 1'b1;
    req_valid = '0; req_addr = '0; req_len = '0;
    dram_ack = 1'b0; dram_data_valid = 1'b0; dram_data_in = '0; err_clr = 1'b0;
    #1;
    do_reset();
    check_en = 1'b1;

    // Single burst with literal expectations.
    set_req(0, 32'h1000_0000, 16'd4);
    tick();
    chk("t1_grant", req_grant_o, 3'b001);
    chk("t1_dram_req", dram_req_o, 1);
    chk("t1_dram_addr", dram_addr_o, 32'h1000_0000);
    chk("t1_dram_len", dram_len_o, 4);
    req_valid[0] = 1'b0;
    dram_ack = 1'b1;
    tick();
    dram_ack = 1'b0;
    chk("t1_req_drop", dram_req_o, 0);
    chk("t1_busy", busy_o, 1);
    for (int j = 0; j < 4; j++) begin
      dram_data_valid = 1'b1;
      dram_data_in    = 16'hA001 + 16'(j);
      tick();
      chk("t1_rsp_valid", rsp_valid_o, 3'b001);
      chk("t1_rsp_data", rsp_data_o, 16'hA001 + 16'(j));
      chk("t1_rsp_last", rsp_last_o, j == 3);
    end
    dram_data_valid = 1'b0;
    chk("t1_idle", busy_o, 0);
    tick();
    chk("t1_quiet", rsp_valid_o, 0);

    // Contention: all three held high, order must be 0,1,2,0,1,2.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'h4000_0000 + 32'(i * 256), 16'd2);
    for (int b = 0; b < 6; b++) run_burst(b % N, 2, 16'(16'hB000 + 16'(b * 16)), 1'b0);
    req_valid = '0;

    // Pointer after a grant to 1: 0 and 2 together go to 2 first.
    set_req(1, 32'h5000_0000, 16'd1);
    run_burst(1, 1, 16'hC000, 1'b1);
    set_req(0, 32'h5000_0100, 16'd1);
    set_req(2, 32'h5000_0200, 16'd1);
    run_burst(2, 1, 16'hC100, 1'b1);
    run_burst(0, 1, 16'hC200, 1'b1);

    // Zero-length request.
    set_req(1, 32'h6000_0000, 16'd0);
    run_burst(1, 0, 16'h0000, 1'b1);
    tick();
    chk("zl_after_req", dram_req_o, 0);
    chk("zl_after_busy", busy_o, 0);

    // Timeout with err_clr held high: the set must win.
    err_clr = 1'b1;
    set_req(0, 32'h2000_0000, 16'd4);
    wait_grant("to");
    chk("to_grant", req_grant_o, 3'b001);
    req_valid[0] = 1'b0;
    n = 0;
    while (dram_req_o && n < 40) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 16);
    chk("to_error_set", error_o, 1);
    chk("to_no_last", rsp_last_o, 0);
    chk("to_busy", busy_o, 0);
    err_clr = 1'b0;
    repeat (5) tick();
    chk("to_sticky", error_o, 1);
    set_req(2, 32'h7000_0000, 16'd1);
    run_burst(2, 1, 16'hD000, 1'b1);
    chk("to_err_during_arb", error_o, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", error_o, 0);

    // Reset in the middle of an 8-beat burst.
    do_reset();
    set_req(0, 32'h8000_0000, 16'd8);
    wait_grant("mid");
    req_valid[0] = 1'b0;
    dram_ack = 1'b1;
    tick();
    dram_ack = 1'b0;
    for (int j = 0; j < 2; j++) begin
      dram_data_valid = 1'b1;
      dram_data_in    = 16'h9000 + 16'(j);
      tick();
    end
    dram_data_valid = 1'b0;
    chk("mid_busy_pre", busy_o, 1);
    do_reset();
    set_req(0, 32'h8000_1000, 16'd3);
    run_burst(0, 3, 16'hE000, 1'b1);
    dram_data_valid = 1'b1;
    dram_data_in    = 16'hEEEE;
    tick();
    dram_data_valid = 1'b0;
    chk("mid_extra_beat", rsp_valid_o, 0);

    // Randomized traffic; a stretch with rare acks provokes timeouts.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_grant_o[i]) begin
          req_valid[i]           = ($urandom_range(0, 1) == 1);
          req_addr[i*AW +: AW]   = $urandom;
          req_len[i*LW +: LW]    = 16'($urandom_range(0, 5));
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_addr[i*AW +: AW]   = $urandom;
          req_len[i*LW +: LW]    = 16'($urandom_range(0, 5));
          req_valid[i]           = 1'b1;
        end
      end
      ack_pct         = (cyc >= 1200 && cyc < 2000) ? 4 : 40;
      dram_ack        = ($urandom_range(0, 99) < ack_pct);
      dram_data_valid = ($urandom_range(0, 9) < 6);
      dram_data_in    = 16'($urandom);
      err_clr         = ($urandom_range(0, 39) == 0);
      tick();
    end
    req_valid = '0; dram_ack = 1'b0; dram_data_valid = 1'b0; err_clr = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
